// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a RUN/HALT FSM
// driving a zero-latency instruction memory.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] imem_data,
    output logic [5:0]  imem_addr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_inst,
    output logic        if_id_valid,
    output logic        halted,
    output logic        fault,
    output logic [15:0] fetch_count
);
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] ECALL    = 32'h0000_0073;
    localparam logic [31:0] EBREAK   = 32'h0010_0073;
    localparam logic [31:0] PC_LIMIT = 32'(IMEM_WORDS) << 2;

    typedef enum logic {RUN, HALT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] if_id_pc_q, if_id_pc_d;
    logic [31:0] if_id_inst_q, if_id_inst_d;
    logic        if_id_valid_q, if_id_valid_d;
    logic        fault_q, fault_d;
    logic [15:0] fetch_count_q, fetch_count_d;
    logic        pc_legal;

    assign pc_legal = (pc_q[1:0] == 2'b00) && (pc_q < PC_LIMIT);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_inst_d  = if_id_inst_q;
        if_id_valid_d = if_id_valid_q;
        fault_d       = fault_q;
        fetch_count_d = fetch_count_q;
        // Redirect beats stall and halt; the target is only checked when fetched.
        if (redirect) begin
            pc_d          = redirect_pc;
            if_id_inst_d  = NOP;
            if_id_valid_d = 1'b0;
            state_d       = RUN;
        end else if (!stall) begin
            if (state_q == HALT) begin
                if_id_inst_d  = NOP;
                if_id_valid_d = 1'b0;
            end else if (!pc_legal) begin
                fault_d       = 1'b1;
                if_id_inst_d  = NOP;
                if_id_valid_d = 1'b0;
                state_d       = HALT;
            end else begin
                if_id_inst_d  = imem_data;
                if_id_pc_d    = pc_q;
                if_id_valid_d = 1'b1;
                if (fetch_count_q != 16'hFFFF)
                    fetch_count_d = fetch_count_q + 16'd1;
                // ECALL/EBREAK is delivered, then the PC parks on it.
                if (imem_data == ECALL || imem_data == EBREAK)
                    state_d = HALT;
                else
                    pc_d = pc_q + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            if_id_pc_q    <= 32'd0;
            if_id_inst_q  <= NOP;
            if_id_valid_q <= 1'b0;
            fault_q       <= 1'b0;
            fetch_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_inst_q  <= if_id_inst_d;
            if_id_valid_q <= if_id_valid_d;
            fault_q       <= fault_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imem_addr   = pc_q[7:2];
    assign if_id_pc    = if_id_pc_q;
    assign if_id_pc4   = if_id_pc_q + 32'd4;
    assign if_id_inst  = if_id_inst_q;
    assign if_id_valid = if_id_valid_q;
    assign halted      = (state_q == HALT);
    assign fault       = fault_q;
    assign fetch_count = fetch_count_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a combinational memory model.
module tb_fetch_stage;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        rst, stall, redirect;
    logic [31:0] redirect_pc, imem_data;
    logic [5:0]  imem_addr;
    logic [31:0] if_id_pc, if_id_pc4, if_id_inst;
    logic        if_id_valid, halted, fault;
    logic [15:0] fetch_count;

    logic [31:0] mem [64];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;
    assign imem_data = mem[imem_addr];

    fetch_stage #(.RESET_PC(32'h0), .IMEM_WORDS(64)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_data(imem_data), .imem_addr(imem_addr),
        .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4), .if_id_inst(if_id_inst),
        .if_id_valid(if_id_valid), .halted(halted), .fault(fault),
        .fetch_count(fetch_count)
    );

    task automatic tick(input string tag);
        @(posedge clk);
        #1;
        $display("[%0t] %s: addr=%0d pc=%h inst=%h v=%0b h=%0b f=%0b cnt=%0d",
                 $time, tag, imem_addr, if_id_pc, if_id_inst, if_id_valid, halted, fault, fetch_count);
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        tick("reset");
        rst = 1'b0;
    endtask

    task automatic init_mem();
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i);
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h44;
        tick("reset_with_stall_redirect");
        n_checks++; if (imem_addr !== 6'd0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", imem_addr); end
        n_checks++; if (if_id_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected 0", if_id_pc); end
        n_checks++; if (if_id_pc4 !== 32'h4) begin n_fail++; $display("FAIL reset_pc4: got %h expected 4", if_id_pc4); end
        n_checks++; if (if_id_inst !== NOP) begin n_fail++; $display("FAIL reset_inst: got %h expected %h", if_id_inst, NOP); end
        n_checks++; if ({if_id_valid, halted, fault} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {if_id_valid, halted, fault}); end
        n_checks++; if (fetch_count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", fetch_count); end
        rst = 1'b0; stall = 1'b0; redirect = 1'b0;
    endtask

    task automatic test_sequential();
        for (int k = 0; k < 4; k++) begin
            tick("seq_fetch");
            n_checks++; if (if_id_pc !== 32'(4 * k)) begin n_fail++; $display("FAIL seq_pc: got %h expected %h", if_id_pc, 32'(4 * k)); end
            n_checks++; if (if_id_pc4 !== 32'(4 * k + 4)) begin n_fail++; $display("FAIL seq_pc4: got %h expected %h", if_id_pc4, 32'(4 * k + 4)); end
            n_checks++; if (if_id_inst !== 32'h1000_0000 + 32'(k) || if_id_valid !== 1'b1) begin n_fail++; $display("FAIL seq_inst: got %h/%b expected %h/1", if_id_inst, if_id_valid, 32'h1000_0000 + 32'(k)); end
        end
        n_checks++; if (fetch_count !== 16'd4) begin n_fail++; $display("FAIL seq_count: got %0d expected 4", fetch_count); end
    endtask

    task automatic test_stall();
        do_reset();
        tick("fetch0");
        tick("fetch4");
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick("stalled");
            n_checks++; if (imem_addr !== 6'd2) begin n_fail++; $display("FAIL stall_addr: got %0d expected 2", imem_addr); end
            n_checks++; if (if_id_pc !== 32'h4 || if_id_inst !== 32'h1000_0001) begin n_fail++; $display("FAIL stall_hold: got %h/%h expected 4/10000001", if_id_pc, if_id_inst); end
            n_checks++; if (fetch_count !== 16'd2) begin n_fail++; $display("FAIL stall_count: got %0d expected 2", fetch_count); end
        end
        stall = 1'b0;
        tick("resume");
        n_checks++; if (if_id_pc !== 32'h8 || if_id_valid !== 1'b1 || fetch_count !== 16'd3) begin n_fail++; $display("FAIL stall_resume: got pc=%h v=%b cnt=%0d expected 8/1/3", if_id_pc, if_id_valid, fetch_count); end
    endtask

    task automatic test_redirect_stall();
        redirect = 1'b1; redirect_pc = 32'h20; stall = 1'b1;
        tick("redirect_stall");
        redirect = 1'b0; stall = 1'b0;
        n_checks++; if (if_id_valid !== 1'b0 || if_id_inst !== NOP) begin n_fail++; $display("FAIL redir_bubble: got %h/%b expected NOP/0", if_id_inst, if_id_valid); end
        n_checks++; if (imem_addr !== 6'd8) begin n_fail++; $display("FAIL redir_addr: got %0d expected 8", imem_addr); end
        n_checks++; if (fetch_count !== 16'd3) begin n_fail++; $display("FAIL redir_count: got %0d expected 3", fetch_count); end
        tick("redirect_target");
        n_checks++; if (if_id_pc !== 32'h20 || if_id_inst !== 32'h1000_0008 || if_id_valid !== 1'b1) begin n_fail++; $display("FAIL redir_fetch: got %h/%h/%b expected 20/10000008/1", if_id_pc, if_id_inst, if_id_valid); end
    endtask

    task automatic test_halt();
        mem[1] = ECALL;
        do_reset();
        tick("fetch0");
        tick("fetch_ecall");
        n_checks++; if (if_id_pc !== 32'h4 || if_id_inst !== ECALL || if_id_valid !== 1'b1) begin n_fail++; $display("FAIL halt_ecall: got %h/%h/%b expected 4/ECALL/1", if_id_pc, if_id_inst, if_id_valid); end
        n_checks++; if (halted !== 1'b1 || imem_addr !== 6'd1) begin n_fail++; $display("FAIL halt_state: got h=%b addr=%0d expected 1/1", halted, imem_addr); end
        for (int k = 0; k < 2; k++) begin
            tick("halted");
            n_checks++; if (if_id_valid !== 1'b0 || if_id_inst !== NOP || imem_addr !== 6'd1 || halted !== 1'b1) begin n_fail++; $display("FAIL halt_hold: got %h/%b addr=%0d h=%b expected NOP/0/1/1", if_id_inst, if_id_valid, imem_addr, halted); end
            n_checks++; if (fetch_count !== 16'd2) begin n_fail++; $display("FAIL halt_count: got %0d expected 2", fetch_count); end
        end
        redirect = 1'b1; redirect_pc = 32'h0;
        tick("redirect_out_of_halt");
        redirect = 1'b0;
        n_checks++; if (halted !== 1'b0 || if_id_valid !== 1'b0 || imem_addr !== 6'd0) begin n_fail++; $display("FAIL halt_release: got h=%b v=%b addr=%0d expected 0/0/0", halted, if_id_valid, imem_addr); end
        mem[3] = EBREAK;
        redirect = 1'b1; redirect_pc = 32'hC;
        tick("redirect_to_ebreak");
        redirect = 1'b0;
        tick("fetch_ebreak");
        n_checks++; if (if_id_inst !== EBREAK || if_id_valid !== 1'b1 || halted !== 1'b1 || imem_addr !== 6'd3) begin n_fail++; $display("FAIL halt_ebreak: got %h/%b h=%b addr=%0d expected EBREAK/1/1/3", if_id_inst, if_id_valid, halted, imem_addr); end
        init_mem();
    endtask

    task automatic test_fault();
        do_reset();
        redirect = 1'b1; redirect_pc = 32'h102;
        tick("redirect_misaligned");
        redirect = 1'b0;
        n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL fault_early: got %b expected 0", fault); end
        tick("fetch_misaligned");
        n_checks++; if (fault !== 1'b1 || halted !== 1'b1 || if_id_valid !== 1'b0 || if_id_inst !== NOP) begin n_fail++; $display("FAIL fault_misaligned: got f=%b h=%b v=%b inst=%h expected 1/1/0/NOP", fault, halted, if_id_valid, if_id_inst); end
        n_checks++; if (fetch_count !== 16'd0) begin n_fail++; $display("FAIL fault_count: got %0d expected 0", fetch_count); end
        redirect = 1'b1; redirect_pc = 32'h100;
        tick("redirect_out_of_range");
        redirect = 1'b0;
        n_checks++; if (halted !== 1'b0 || fault !== 1'b1) begin n_fail++; $display("FAIL fault_redirect: got h=%b f=%b expected 0/1", halted, fault); end
        tick("fetch_out_of_range");
        n_checks++; if (fault !== 1'b1 || halted !== 1'b1 || if_id_valid !== 1'b0) begin n_fail++; $display("FAIL fault_range: got f=%b h=%b v=%b expected 1/1/0", fault, halted, if_id_valid); end
        redirect = 1'b1; redirect_pc = 32'h0;
        tick("redirect_legal");
        redirect = 1'b0;
        n_checks++; if (halted !== 1'b0 || fault !== 1'b1) begin n_fail++; $display("FAIL fault_sticky: got h=%b f=%b expected 0/1", halted, fault); end
        tick("fetch_after_fault");
        n_checks++; if (if_id_pc !== 32'h0 || if_id_valid !== 1'b1 || fault !== 1'b1 || fetch_count !== 16'd1) begin n_fail++; $display("FAIL fault_resume: got pc=%h v=%b f=%b cnt=%0d expected 0/1/1/1", if_id_pc, if_id_valid, fault, fetch_count); end
    endtask

    task automatic test_reset_halt();
        mem[1] = ECALL;
        tick("fetch_ecall");
        tick("halted");
        n_checks++; if (halted !== 1'b1 || fault !== 1'b1) begin n_fail++; $display("FAIL rsthalt_pre: got h=%b f=%b expected 1/1", halted, fault); end
        rst = 1'b1; stall = 1'b1;
        tick("reset_while_halted");
        rst = 1'b0; stall = 1'b0;
        n_checks++; if (imem_addr !== 6'd0 || halted !== 1'b0 || fault !== 1'b0 || if_id_valid !== 1'b0 || fetch_count !== 16'd0) begin n_fail++; $display("FAIL rsthalt_state: got addr=%0d h=%b f=%b v=%b cnt=%0d expected 0/0/0/0/0", imem_addr, halted, fault, if_id_valid, fetch_count); end
        mem[1] = 32'h1000_0001;
        tick("first_fetch");
        n_checks++; if (if_id_pc !== 32'h0 || if_id_valid !== 1'b1 || fetch_count !== 16'd1) begin n_fail++; $display("FAIL rsthalt_first: got pc=%h v=%b cnt=%0d expected 0/1/1", if_id_pc, if_id_valid, fetch_count); end
    endtask

    initial begin
        init_mem();
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_stall();
        test_halt();
        test_fault();
        test_reset_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
